// File: rtl/dmem_responder_pkg.sv
// Shared encodings for the data-memory responder: access sizes, FSM states, word width.
// Optional error detection is enabled by defining DMEM_RSP_ERR_EN.
package dmem_responder_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  // True when the low address bits do not match the natural alignment of the size.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
    logic w_bad;
    w_bad = 1'b0;
    case (size)
      SZ_H:    w_bad = lane[0];
      SZ_W:    w_bad = (lane != 2'b00);
      default: w_bad = 1'b0;
    endcase
    return w_bad;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: merges store data into a word and extracts/extends load data.
// Half accesses use addr[1] only; word and the unused size 11 take the whole word.
module dmem_lane_align
  import dmem_responder_pkg::*;
(
  input  logic [WORD_W-1:0] i_old_word,
  input  logic [WORD_W-1:0] i_wdata,
  input  logic [1:0]        i_size,
  input  logic [1:0]        i_lane,
  input  logic              i_unsigned,
  output logic [WORD_W-1:0] o_new_word,
  output logic [WORD_W-1:0] o_rdata
);

  logic [4:0]  w_bsh;
  logic [4:0]  w_hsh;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // NOTE: every output gets a default before the case so no path can infer a latch.
  always_comb begin
    w_bsh      = {i_lane, 3'b000};
    w_hsh      = {i_lane[1], 4'b0000};
    w_byte     = i_old_word[w_bsh +: 8];
    w_half     = i_old_word[w_hsh +: 16];
    o_new_word = i_old_word;
    o_rdata    = i_old_word;
    case (i_size)
      SZ_B: begin
        o_new_word[w_bsh +: 8] = i_wdata[7:0];
        o_rdata = {{24{~i_unsigned & w_byte[7]}}, w_byte};
      end
      SZ_H: begin
        o_new_word[w_hsh +: 16] = i_wdata[15:0];
        o_rdata = {{16{~i_unsigned & w_half[15]}}, w_half};
      end
      default: begin
        o_new_word = i_wdata;
        o_rdata    = i_old_word;
      end
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: request handshake, WAIT_CYCLES wait states, response handshake.
// Define DMEM_RSP_ERR_EN to reject illegal size, misaligned and out-of-range accesses.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH       = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [1:0]              req_size,
  input  logic                    req_unsigned,
  input  logic [31:0]             req_addr,
  input  logic [31:0]             req_wdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [31:0]             rsp_rdata,
  output logic                    rsp_err,
  output logic [DEPTH*WORD_W-1:0] dmem
);

  localparam int IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_LOAD = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
  localparam int CNT_W    = (CNT_LOAD > 0) ? $clog2(CNT_LOAD + 1) : 1;

  state_e            r_state;
  state_e            w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_we;
  logic [1:0]        r_size;
  logic              r_unsigned;
  logic [31:0]       r_addr;
  logic [31:0]       r_wdata;
  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [31:0]       r_rdata;
  logic              r_err;

  logic              w_accept;
  logic              w_enter_resp;
  logic              w_src_we;
  logic [1:0]        w_src_size;
  logic              w_src_unsigned;
  logic [31:0]       w_src_addr;
  logic [31:0]       w_src_wdata;
  logic [29:0]       w_word_addr;
  logic [29:0]       w_idx_full;
  logic [IDX_W-1:0]  w_idx;
  logic              w_err;
  logic [WORD_W-1:0] w_old_word;
  logic [WORD_W-1:0] w_new_word;
  logic [WORD_W-1:0] w_load;

  assign w_accept     = (r_state == ST_IDLE) && req_valid;
  assign w_enter_resp = (w_next == ST_RESP) && (r_state != ST_RESP);

  // With no wait states the access happens on the accept edge itself, so it uses the live request.
  assign w_src_we       = (r_state == ST_IDLE) ? req_we       : r_we;
  assign w_src_size     = (r_state == ST_IDLE) ? req_size     : r_size;
  assign w_src_unsigned = (r_state == ST_IDLE) ? req_unsigned : r_unsigned;
  assign w_src_addr     = (r_state == ST_IDLE) ? req_addr     : r_addr;
  assign w_src_wdata    = (r_state == ST_IDLE) ? req_wdata    : r_wdata;

  assign w_word_addr = w_src_addr[31:2];
  assign w_idx_full  = w_word_addr % 30'(DEPTH);
  assign w_idx       = w_idx_full[IDX_W-1:0];
  assign w_old_word  = r_mem[w_idx];

`ifdef DMEM_RSP_ERR_EN
  assign w_err = (w_src_size == 2'b11) || misaligned(w_src_size, w_src_addr[1:0]) ||
                 (w_word_addr >= 30'(DEPTH));
`else
  assign w_err = 1'b0;
`endif

  dmem_lane_align u_align (
    .i_old_word (w_old_word),
    .i_wdata    (w_src_wdata),
    .i_size     (w_src_size),
    .i_lane     (w_src_addr[1:0]),
    .i_unsigned (w_src_unsigned),
    .o_new_word (w_new_word),
    .o_rdata    (w_load)
  );

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (req_valid) w_next = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
      ST_WAIT: if (r_cnt == '0) w_next = ST_RESP;
      ST_RESP: if (rsp_ready) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt      <= '0;
      r_we       <= 1'b0;
      r_size     <= 2'b00;
      r_unsigned <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
    end else if (w_accept) begin
      r_cnt      <= CNT_W'(CNT_LOAD);
      r_we       <= req_we;
      r_size     <= req_size;
      r_unsigned <= req_unsigned;
      r_addr     <= req_addr;
      r_wdata    <= req_wdata;
    end else if (r_state == ST_WAIT && r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // NOTE: the array is reset because reset must observably clear every word; real SRAM macros could not.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else if (w_enter_resp) begin
      if (w_src_we && !w_err) r_mem[w_idx] <= w_new_word;
      r_rdata <= (w_err || w_src_we) ? '0 : w_load;
      r_err   <= w_err;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_dump
    assign dmem[g*WORD_W +: WORD_W] = r_mem[g];
  end

  assign req_ready = (r_state == ST_IDLE);
  assign rsp_valid = (r_state == ST_RESP);
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed table, random traffic against a byte-level model,
// reset/backpressure/error sequences, and a zero-wait-state throughput run.
module tb_dmem_responder;

  localparam int DEPTH = 32;
  localparam int WC1   = 1;

  logic clk = 1'b0;
  logic reset = 1'b0;

  logic              req_valid = 0, req_we = 0, req_unsigned = 0, rsp_ready = 0;
  logic [1:0]        req_size = 0;
  logic [31:0]       req_addr = 0, req_wdata = 0;
  logic              req_ready, rsp_valid, rsp_err;
  logic [31:0]       rsp_rdata;
  logic [DEPTH*32-1:0] dmem;

  logic              b_valid = 0, b_we = 0, b_unsigned = 0, b_rsp_ready = 0;
  logic [1:0]        b_size = 0;
  logic [31:0]       b_addr = 0, b_wdata = 0;
  logic              b_ready, b_rsp_valid, b_err;
  logic [31:0]       b_rdata;
  logic [DEPTH*32-1:0] b_dmem;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem_b [DEPTH*4];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WC1)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .dmem(dmem)
  );

  dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset),
    .req_valid(b_valid), .req_ready(b_ready), .req_we(b_we), .req_size(b_size),
    .req_unsigned(b_unsigned), .req_addr(b_addr), .req_wdata(b_wdata),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rdata), .rsp_err(b_err),
    .dmem(b_dmem)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s timed out", name);
  endtask

  // Reference model: memory as a flat byte array, rules applied directly.
  function automatic bit model_err(input logic [1:0] size, input logic [31:0] addr);
`ifdef DMEM_RSP_ERR_EN
    return (size == 2'b11) || (size == 2'b01 && addr[0]) ||
           (size == 2'b10 && addr[1:0] != 2'b00) || ((addr >> 2) >= DEPTH);
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_apply(input logic we, input logic [1:0] size, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             output logic [31:0] rdata, output logic err);
    int n, widx, off, base;
    logic [31:0] val, mask;
    err   = model_err(size, addr);
    rdata = 32'h0;
    if (err) return;
    n    = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    widx = int'((addr >> 2) % DEPTH);
    off  = (int'(addr % 4) / n) * n;
    base = widx * 4 + off;
    if (we) begin
      for (int k = 0; k < n; k++) begin
        val = wdata >> (8 * k);
        mem_b[base + k] = val[7:0];
      end
    end else begin
      val = 32'h0;
      for (int k = 0; k < n; k++) val = val | (32'(mem_b[base + k]) << (8 * k));
      if (n < 4 && !uns) begin
        mask = (32'd1 << (8 * n)) - 32'd1;
        if (val[8 * n - 1]) val = val | ~mask;
      end
      rdata = val;
    end
  endtask

  function automatic logic [31:0] model_word(input int i);
    return {mem_b[4*i+3], mem_b[4*i+2], mem_b[4*i+1], mem_b[4*i]};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH * 4; i++) mem_b[i] = 8'h00;
  endtask

  task automatic check_words(input string tag);
    for (int i = 0; i < DEPTH; i++)
      check($sformatf("%s_word%0d", tag, i), dmem[32*i +: 32], model_word(i));
  endtask

  // One full transaction on the WAIT_CYCLES=1 instance, checked against the model.
  task automatic txn(input logic we, input logic [1:0] size, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wdata, input string tag,
                     output logic [31:0] got_rdata, output logic got_err);
    int n;
    logic [31:0] exp_rdata;
    logic exp_err;
    got_rdata = 32'hx;
    got_err   = 1'bx;
    @(negedge clk);
    req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready) begin
      @(negedge clk);
      n++;
      if (n > 50) begin
        timeout({tag, "_accept"});
        req_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n <= 50) begin
      @(negedge clk);
      n++;
    end
    if (!rsp_valid) begin
      timeout({tag, "_rsp"});
      return;
    end
    check({tag, "_latency"}, 32'(n), 32'(WC1));
    model_apply(we, size, uns, addr, wdata, exp_rdata, exp_err);
    got_rdata = rsp_rdata;
    got_err   = rsp_err;
    check({tag, "_rdata"}, rsp_rdata, exp_rdata);
    check({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
    check({tag, "_ready_in_resp"}, 32'(req_ready), 32'h0);
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, "_valid_done"}, 32'(rsp_valid), 32'h0);
    check({tag, "_ready_done"}, 32'(req_ready), 32'h1);
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int          widx;
    logic [31:0] exp_word;
  } vec_t;

  function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp_rdata, input int widx,
                              input logic [31:0] exp_word);
    vec_t v;
    v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.widx = widx; v.exp_word = exp_word;
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    vec_t vt[16];
    logic [31:0] rd, first_rd;
    logic er;
    int n;

    vt[0]  = mk(1, 2'b10, 0, 32'h08, 32'hDEADBEEF, 32'h0,        2,  32'hDEADBEEF);
    vt[1]  = mk(1, 2'b10, 0, 32'h08, 32'h00000000, 32'h0,        2,  32'h00000000);
    vt[2]  = mk(1, 2'b00, 0, 32'h0B, 32'h00000080, 32'h0,        2,  32'h80000000);
    vt[3]  = mk(0, 2'b00, 0, 32'h0B, 32'h0,        32'hFFFFFF80, 2,  32'h80000000);
    vt[4]  = mk(0, 2'b00, 1, 32'h0B, 32'h0,        32'h00000080, 2,  32'h80000000);
    vt[5]  = mk(1, 2'b01, 0, 32'h0E, 32'h1234ABCD, 32'h0,        3,  32'hABCD0000);
    vt[6]  = mk(0, 2'b01, 0, 32'h0E, 32'h0,        32'hFFFFABCD, 3,  32'hABCD0000);
    vt[7]  = mk(0, 2'b01, 1, 32'h0E, 32'h0,        32'h0000ABCD, 3,  32'hABCD0000);
    vt[8]  = mk(0, 2'b10, 0, 32'h0C, 32'h0,        32'hABCD0000, 3,  32'hABCD0000);
    vt[9]  = mk(1, 2'b00, 0, 32'h0D, 32'hFFFFFF5A, 32'h0,        3,  32'hABCD5A00);
    vt[10] = mk(0, 2'b10, 1, 32'h0C, 32'h0,        32'hABCD5A00, 3,  32'hABCD5A00);
    vt[11] = mk(1, 2'b10, 0, 32'h7C, 32'h7FFF0001, 32'h0,        31, 32'h7FFF0001);
    vt[12] = mk(0, 2'b01, 0, 32'h7C, 32'h0,        32'h00000001, 31, 32'h7FFF0001);
    vt[13] = mk(0, 2'b01, 0, 32'h7E, 32'h0,        32'h00007FFF, 31, 32'h7FFF0001);
    vt[14] = mk(0, 2'b00, 0, 32'h7F, 32'h0,        32'h0000007F, 31, 32'h7FFF0001);
    vt[15] = mk(0, 2'b00, 0, 32'h0E, 32'h0,        32'hFFFFFFCD, 3,  32'hABCD5A00);

    model_clear();

    // Reset state, observed while reset is held.
    repeat (2) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'h1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_err", 32'(rsp_err), 32'h0);
    check_words("rst");
    reset = 1'b1;
    @(negedge clk);

    // Directed table.
    for (int i = 0; i < 16; i++) begin
      txn(vt[i].we, vt[i].size, vt[i].uns, vt[i].addr, vt[i].wdata, $sformatf("vec%0d", i), rd, er);
      check($sformatf("vec%0d_tbl_rdata", i), rd, vt[i].exp_rdata);
      check($sformatf("vec%0d_tbl_err", i), 32'(er), 32'h0);
      check($sformatf("vec%0d_tbl_word", i), dmem[32*vt[i].widx +: 32], vt[i].exp_word);
    end
    check_words("table");

    // Reset in the middle of the wait state of a word store to 0x10.
    @(negedge clk);
    req_we = 1; req_size = 2'b10; req_unsigned = 0; req_addr = 32'h10; req_wdata = 32'hCAFEF00D;
    req_valid = 1'b1;
    check("midwait_ready_before", 32'(req_ready), 32'h1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("midwait_in_wait", 32'(rsp_valid), 32'h0);
    reset = 1'b0;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("midwait_word4", dmem[32*4 +: 32], 32'h0);
    check("midwait_req_ready", 32'(req_ready), 32'h1);
    check("midwait_rsp_valid", 32'(rsp_valid), 32'h0);
    check_words("midwait");

    // Random traffic against the model.
    for (int i = 0; i < 80; i++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(128, 255)) : 32'($urandom_range(0, 127));
      txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
          a, $urandom, $sformatf("rnd%0d", i), rd, er);
      check_words($sformatf("rnd%0d", i));
    end

    // Response backpressure: hold rsp_ready low for 5 cycles in RESP.
    txn(1, 2'b10, 0, 32'h20, 32'h13579BDF, "bp_store", rd, er);
    @(negedge clk);
    req_we = 0; req_size = 2'b10; req_unsigned = 0; req_addr = 32'h20; req_wdata = 32'h0;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n <= 50) begin
      @(negedge clk);
      n++;
    end
    if (!rsp_valid) timeout("bp_rsp");
    first_rd = rsp_rdata;
    check("bp_rdata", first_rd, 32'h13579BDF);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("bp_hold%0d_valid", i), 32'(rsp_valid), 32'h1);
      check($sformatf("bp_hold%0d_rdata", i), rsp_rdata, 32'h13579BDF);
      check($sformatf("bp_hold%0d_err", i), 32'(rsp_err), 32'h0);
      check($sformatf("bp_hold%0d_ready", i), 32'(req_ready), 32'h0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check("bp_done_valid", 32'(rsp_valid), 32'h0);
    check("bp_done_ready", 32'(req_ready), 32'h1);

    // Error candidates: misaligned half store, out-of-range word load, illegal size.
    txn(1, 2'b01, 0, 32'h05, 32'h0000FFFF, "err_half", rd, er);
    check_words("err_half");
    txn(0, 2'b10, 0, 32'h80, 32'h0, "err_range", rd, er);
    txn(1, 2'b11, 0, 32'h14, 32'h89ABCDEF, "err_size", rd, er);
    check_words("err_size");
    txn(0, 2'b10, 0, 32'h07, 32'h0, "err_word_mis", rd, er);

    // Zero wait states with both handshakes held high: accept every second cycle.
    @(negedge clk);
    b_rsp_ready = 1'b1;
    b_valid = 1'b1;
    b_we = 1'b1;
    b_size = 2'b10;
    b_unsigned = 1'b0;
    for (int i = 0; i < 12; i++) begin
      b_addr  = 32'(4 * (i % 8));
      b_wdata = 32'h100 + 32'(i);
      check($sformatf("wc0_c%0d_ready", i), 32'(b_ready), 32'((i % 2) == 0));
      check($sformatf("wc0_c%0d_valid", i), 32'(b_rsp_valid), 32'((i % 2) == 1));
      if ((i % 2) == 1) begin
        check($sformatf("wc0_c%0d_rdata", i), b_rdata, 32'h0);
        check($sformatf("wc0_c%0d_err", i), 32'(b_err), 32'h0);
      end
      @(negedge clk);
    end
    b_valid = 1'b0;
    b_rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("wc0_word0", b_dmem[32*0 +: 32], 32'h108);
    check("wc0_word1", b_dmem[32*1 +: 32], 32'h0);
    check("wc0_word2", b_dmem[32*2 +: 32], 32'h10A);
    check("wc0_word3", b_dmem[32*3 +: 32], 32'h0);
    check("wc0_word4", b_dmem[32*4 +: 32], 32'h104);
    check("wc0_word6", b_dmem[32*6 +: 32], 32'h106);
    check("wc0_word7", b_dmem[32*7 +: 32], 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the core's load/store port: it accepts one request at a time over a valid/ready handshake and inserts a configurable number of wait states. It performs byte, half or word reads and writes into a word-organised array, then returns a sign- or zero-extended response over a second valid/ready handshake. It sits at the memory end of the datapath's data bus and replaces the combinational data memory when multi-cycle memory timing is modelled. A flattened dump of the array is exported for the bench.

## Interface
Parameters:
- `DEPTH` — default 32 — number of 32-bit words.
- `WAIT_CYCLES` — default 1 — wait states between accept and access; 0 is legal.

Ports:
- `clk` — in — 1 — single clock; rising edge.
- `reset` — in — 1 — asynchronous, active-low.
- `req_valid` — in — 1 — request present.
- `req_ready` — out — 1 — responder can accept.
- `req_we` — in — 1 — 1 = store, 0 = load.
- `req_size` — in — 2 — 00 byte, 01 half, 10 word, 11 illegal.
- `req_unsigned` — in — 1 — load zero-extends when 1, sign-extends when 0.
- `req_addr` — in — 32 — byte address.
- `req_wdata` — in — 32 — store data, right-aligned.
- `rsp_valid` — out — 1 — response present.
- `rsp_ready` — in — 1 — requester takes response.
- `rsp_rdata` — out — 32 — load result; 0 for stores and errors.
- `rsp_err` — out — 1 — request rejected.
- `dmem` — out — DEPTH*32 — array dump; word i is at bits [32*i+31:32*i].

## Operation
- **FSM states:**
  - IDLE: `req_ready`=1. A request is accepted when `req_valid` and `req_ready` are both high at an edge. On accept, latch we/size/unsigned/addr/wdata and go to WAIT, or to RESP directly if `WAIT_CYCLES`=0.
  - WAIT: counter loads `WAIT_CYCLES`-1 on entry and decrements each cycle; at 0 → RESP.
  - RESP: `rsp_valid`=1. `rsp_rdata` and `rsp_err` are held stable until `rsp_valid` and `rsp_ready` are both high at an edge → IDLE.
- **Access timing:** the access is performed on the edge that enters RESP.
  - Stores write the array at that edge.
  - Loads register the extracted data at that edge.
- **Word index:** `req_addr[31:2]`.
- **Stores:**
  - Byte: `wdata[7:0]` goes to lane `addr[1:0]`.
  - Half: `wdata[15:0]` goes to lanes {`addr[1]`*2+1, `addr[1]`*2}.
  - Word: full word.
  - Untouched lanes keep their contents.
- **Loads:** select the same lane(s), then zero- or sign-extend to 32 bits per `req_unsigned`. Word loads ignore `req_unsigned`.
- **Error conditions** (with `DMEM_RSP_ERR_EN`):
  - size 11;
  - half access with `addr[0]`=1;
  - word access with `addr[1:0]`≠0;
  - `addr[31:2]` ≥ `DEPTH`.
- **On error:** no array write, `rsp_rdata`=0, `rsp_err`=1; the handshake completes normally.
- **No overlap:** `req_ready`=0 in WAIT and RESP, including the RESP cycle in which the response completes. The next request is accepted in the following IDLE cycle.
- **Reset:** asserting `reset` (low) at any time forces IDLE and clears every array word to 0. An in-flight store whose RESP-entry edge has not occurred is discarded.

## Timing
- **Reset values:** `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `dmem`=0.
- **Latency:** accept at edge E0 → `rsp_valid` high in the cycle after edge E0+`WAIT_CYCLES`.
- **Throughput:** with `rsp_ready` tied high, one transaction per `WAIT_CYCLES`+2 cycles.
- **`dmem` update:** reflects a store from the edge that enters RESP.
- **Registered outputs:** `req_ready` and `rsp_valid` are decoded from state registers only and never depend combinationally on inputs.

## Configuration
- **`DMEM_RSP_ERR_EN` defined:** error detection as in Operation.
- **`DMEM_RSP_ERR_EN` undefined:**
  - `rsp_err` is tied 0.
  - Misaligned addresses are force-aligned by ignoring `addr[0]` for half and `addr[1:0]` for word.
  - Size 11 is treated as word.
  - The word index wraps modulo `DEPTH`.

## Structure
- **Shared package/include:**
  - size encodings `SZ_B`, `SZ_H`, `SZ_W`;
  - state encodings `ST_IDLE`, `ST_WAIT`, `ST_RESP`;
  - the word-width constant.
- **Sub-module `dmem_lane_align`:** purely combinational. It performs the store byte-merge (old word, wdata, size, `addr[1:0]` → new word) and the load extract/extend (word, size, `addr[1:0]`, unsigned → 32 bits). The FSM, counter and array stay in `dmem_responder`.

## Test plan
1. Reset low mid-WAIT of a word store to 0x10 → after release, `dmem` word 4 = 0, `req_ready`=1, `rsp_valid`=0.
2. `WAIT_CYCLES`=1: store word 0xDEADBEEF at 0x08, accept at edge E0 → `rsp_valid` visible after E0+1, `rsp_err`=0, `dmem` word 2 = 0xDEADBEEF.
3. Store byte 0x80 at 0x0B over 0x00000000, then load byte signed and load byte unsigned at 0x0B → 0xFFFFFF80 and 0x00000080; word 2 = 0x80000000.
4. Hold `rsp_ready`=0 for 5 cycles in RESP → `rsp_valid`, `rsp_rdata` and `rsp_err` stable and `req_ready`=0 throughout; completion on the first edge with `rsp_ready`=1.
5. With `DMEM_RSP_ERR_EN`: half store at 0x05 and word load at 0x80 with `DEPTH`=32 → `rsp_err`=1, `rsp_rdata`=0, array unchanged.
6. `WAIT_CYCLES`=0 with `req_valid` and `rsp_ready` held high → accepts occur every 2nd cycle, each with 1-cycle latency.
